// File: rtl/deskew_collector.sv
// deskew_collector
//   Takes the diagonally skewed result wavefront from the systolic array and
//   re-aligns it into whole row vectors. Lane i arrives i cycles after lane 0.
//   Each aligned vector is stored in a circular FIFO and handed to a
//   valid/ready consumer. Ingress is credit-gated: a wavefront is accepted
//   only if a FIFO slot is already reserved for it. Wavefronts still in the
//   delay pipeline are counted as reserved, so storage can never overflow.
//
// Ports
//   clk          clock
//   rst_n        asynchronous, active-low reset
//   in_valid_i   start of a wavefront; lane 0 of in_data_i is valid this cycle
//   in_ready_o   credit available; a wavefront is accepted on valid & ready
//   in_data_i    lane i at [i*BITS +: BITS], valid i cycles after the accept
//   out_valid_o  FIFO head present
//   out_ready_i  consumer pops the head on out_valid_o & out_ready_i
//   out_data_o   FIFO head in unchanged lane order; zero when empty
//   count_o      FIFO occupancy, not counting wavefronts still in flight
module deskew_collector #(
  parameter  int DIM       = 8,
  parameter  int BITS      = 64,
  parameter  int OUT_DEPTH = 16,
  localparam int CNT_W     = $clog2(OUT_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DIM*BITS-1:0]   in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DIM*BITS-1:0]   out_data_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  // Wide enough to hold count plus every in-flight wavefront without wrapping.
  localparam int SUM_W = $clog2(OUT_DEPTH + DIM + 1);

  logic [DIM-2:0]          vld_q, vld_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DIM*BITS-1:0]     mem_q [OUT_DEPTH];
  logic [DIM*BITS-1:0]     wr_vec;
  logic [SUM_W-1:0]        occ_sum;
  logic                    accept;
  logic                    push;
  logic                    pop;

  // Pointer increment that wraps at OUT_DEPTH, including non-power-of-2 depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept = in_valid_i & in_ready_o;
  assign push   = vld_q[DIM-2];
  assign pop    = out_valid_o & out_ready_i;

  // Valid pipeline: vld_q[k] means a wavefront was accepted k+1 edges ago.
  // It never stalls, because credit already reserved a FIFO slot.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int k = 1; k < DIM - 1; k++) begin
      vld_d[k] = vld_q[k-1];
    end
  end

  // Lane i passes through DIM-1-i registers, so every lane reaches the write
  // port on the same edge. The registers shift freely. Values outside a
  // lane's slot are never written because push is keyed off vld_q alone.
  for (genvar i = 0; i < DIM - 1; i++) begin : g_lane
    localparam int STAGES = DIM - 1 - i;
    logic [BITS-1:0] pipe_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < STAGES; s++) begin
          pipe_q[s] <= '0;
        end
      end else begin
        pipe_q[0] <= in_data_i[i*BITS +: BITS];
        for (int s = 1; s < STAGES; s++) begin
          pipe_q[s] <= pipe_q[s-1];
        end
      end
    end

    assign wr_vec[i*BITS +: BITS] = pipe_q[STAGES-1];
  end

  // The last lane arrives on the write edge itself, so it needs no delay.
  assign wr_vec[(DIM-1)*BITS +: BITS] = in_data_i[(DIM-1)*BITS +: BITS];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Credit uses registered state only. A pop on the same edge is not
  // credited back until the next cycle.
  always_comb begin
    occ_sum = SUM_W'(count_q);
    for (int k = 0; k < DIM - 1; k++) begin
      occ_sum = occ_sum + SUM_W'(vld_q[k]);
    end
  end

  assign in_ready_o  = occ_sum < SUM_W'(OUT_DEPTH);
  assign out_valid_o = (count_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o     = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < OUT_DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_vec;
    end
  end

endmodule

// File: tb/tb_deskew_collector.sv
// tb_deskew_collector
//   Directed bench for deskew_collector. dut_a uses the default geometry
//   (DIM=8, BITS=64, OUT_DEPTH=16). dut_b uses DIM=4, OUT_DEPTH=5 to cover a
//   non-power-of-2 depth. Lanes are driven with the input skew: lane i
//   carries wavefront k's value i cycles after k was accepted, and random
//   garbage in every other cycle. Wavefront k lane i holds k*16+i.
module tb_deskew_collector;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [511:0] in_data_a, out_data_a;
  logic [4:0]   count_a;

  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [255:0] in_data_b, out_data_b;
  logic [2:0]   count_b;

  int           n_checks = 0;
  int           n_err    = 0;
  string        phase    = "init";

  bit           sel;
  int           hist [8];
  logic [511:0] exp_q [$];
  int           next_id;

  always #5 clk = ~clk;

  deskew_collector #(.DIM(8), .BITS(64), .OUT_DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_data_i(in_data_a),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_a), .out_data_o(out_data_a),
    .count_o(count_a)
  );

  deskew_collector #(.DIM(4), .BITS(64), .OUT_DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_data_i(in_data_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_data_o(out_data_b),
    .count_o(count_b)
  );

  function automatic logic [63:0] val(input int k, input int i);
    return 64'(k * 16 + i);
  endfunction

  function automatic logic [511:0] vec_of(input int k, input int dim);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < dim; i++) v[i*64 +: 64] = val(k, i);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int k = 0; k < 8; k++) hist[k] = -1;
  endtask

  // One clock cycle. Entered 1 time unit after a rising edge. It checks the
  // outputs against the reference queue, drives the inputs with the skew
  // applied, advances one edge, and updates the model.
  task automatic cycle(input bit v, input bit r);
    int           dim, depth, infl, k, push_id;
    bit           o_rdy, o_vld, exp_rdy, acc, pushed, popped;
    int           o_cnt;
    logic [511:0] o_data, exp_head, d;

    dim   = sel ? 4 : 8;
    depth = sel ? 5 : 16;
    if (sel) begin
      o_rdy = in_ready_b; o_vld = out_valid_b; o_cnt = int'(count_b);
      o_data = {256'b0, out_data_b};
    end else begin
      o_rdy = in_ready_a; o_vld = out_valid_a; o_cnt = int'(count_a);
      o_data = out_data_a;
    end

    infl = 0;
    for (int j = 1; j < dim; j++) if (hist[j] >= 0) infl++;
    exp_rdy  = (exp_q.size() + infl) < depth;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("in_ready",  512'(o_rdy), 512'(exp_rdy));
    chk("out_valid", 512'(o_vld), 512'(exp_q.size() != 0));
    chk("count",     512'(o_cnt), 512'(exp_q.size()));
    chk("out_data",  o_data, exp_head);

    d = '0;
    for (int i = 0; i < dim; i++) begin
      k = (i == 0) ? (v ? next_id : -1) : hist[i];
      d[i*64 +: 64] = (k >= 0) ? val(k, i) : {$urandom, $urandom};
    end

    acc     = v & o_rdy;
    push_id = hist[dim-1];
    pushed  = (push_id >= 0);
    popped  = r & (exp_q.size() != 0);

    if (!sel) begin
      in_valid_a = v; out_ready_a = r; in_data_a = d;
      in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    end else begin
      in_valid_b = v; out_ready_b = r; in_data_b = d[255:0];
      in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
    end

    @(posedge clk);
    #1;

    if (popped) void'(exp_q.pop_front());
    if (pushed) exp_q.push_back(vec_of(push_id, dim));
    for (int j = dim - 1; j >= 2; j--) hist[j] = hist[j-1];
    hist[1] = acc ? next_id : -1;
    if (acc) next_id++;
  endtask

  initial begin
    int first, nv, nlow, run, maxrun, nacc, npop, mx, base;
    bit vv, rr;
    logic [511:0] cap;

    rst_n = 1'b0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_data_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_data_b = '0;
    sel = 1'b0;
    next_id = 16;
    model_clear();

    // Reset values
    phase = "reset";
    repeat (3) @(posedge clk);
    #1;
    chk("a_in_ready",  512'(in_ready_a),  512'(1));
    chk("a_out_valid", 512'(out_valid_a), 512'(0));
    chk("a_out_data",  out_data_a,        '0);
    chk("a_count",     512'(count_a),     512'(0));
    chk("b_in_ready",  512'(in_ready_b),  512'(1));
    chk("b_count",     512'(count_b),     512'(0));
    rst_n = 1'b1;

    // Single wavefront: lanes 0x100..0x107, out_valid for exactly one cycle
    // after the 7th edge following the accept.
    phase = "single";
    cycle(1'b1, 1'b1);
    first = -1; nv = 0; cap = '0;
    for (int j = 0; j < 12; j++) begin
      if (out_valid_a) begin
        if (first < 0) first = j;
        nv++;
        cap = out_data_a;
      end
      cycle(1'b0, 1'b1);
    end
    chk("latency", 512'(first), 512'(7));
    chk("valid_cycles", 512'(nv), 512'(1));
    chk("lanes", cap, 512'h0000000000000107_0000000000000106_0000000000000105_0000000000000104_0000000000000103_0000000000000102_0000000000000101_0000000000000100);
    chk("count_end", 512'(count_a), 512'(0));

    // Streaming: 20 back-to-back wavefronts with out_ready held high.
    phase = "stream";
    nlow = 0; run = 0; maxrun = 0;
    for (int j = 0; j < 32; j++) begin
      if (j < 20 && !in_ready_a) nlow++;
      if (out_valid_a) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      cycle(j < 20, 1'b1);
    end
    chk("ready_drops", 512'(nlow), 512'(0));
    chk("valid_run", 512'(maxrun), 512'(20));
    chk("count_end", 512'(count_a), 512'(0));

    // Backpressure: in_valid held high with out_ready low.
    phase = "backpressure";
    nacc = 0; mx = 0;
    for (int j = 0; j < 30; j++) begin
      if (in_ready_a) nacc++;
      cycle(1'b1, 1'b0);
      if (int'(count_a) > mx) mx = int'(count_a);
    end
    chk("accepts", 512'(nacc), 512'(16));
    chk("peak_count", 512'(mx), 512'(16));
    chk("ready_low", 512'(in_ready_a), 512'(0));
    npop = 0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid_a) npop++;
      cycle(1'b0, 1'b1);
    end
    chk("drained", 512'(npop), 512'(16));
    chk("count_end", 512'(count_a), 512'(0));

    // Simultaneous push and pop with 15 entries stored.
    phase = "push_pop";
    base = next_id;
    for (int j = 0; j < 15; j++) cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("count_15", 512'(count_a), 512'(15));
    chk("head_before", out_data_a, vec_of(base, 8));
    cycle(1'b1, 1'b0);
    repeat (6) cycle(1'b0, 1'b0);
    chk("count_pre", 512'(count_a), 512'(15));
    cycle(1'b0, 1'b1);
    chk("count_post", 512'(count_a), 512'(15));
    chk("head_after", out_data_a, vec_of(base + 1, 8));
    repeat (20) cycle(1'b0, 1'b1);
    chk("count_end", 512'(count_a), 512'(0));

    // Reset with one stored entry and two wavefronts in flight.
    phase = "reset_mid";
    cycle(1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b0);
    chk("count_1", 512'(count_a), 512'(1));
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("in_ready",  512'(in_ready_a),  512'(1));
    chk("out_valid", 512'(out_valid_a), 512'(0));
    chk("out_data",  out_data_a,        '0);
    chk("count",     512'(count_a),     512'(0));
    model_clear();
    repeat (2) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    base = next_id;
    cycle(1'b1, 1'b1);
    first = -1; nv = 0; cap = '0;
    for (int j = 0; j < 20; j++) begin
      if (out_valid_a) begin
        if (first < 0) first = j;
        nv++;
        cap = out_data_a;
      end
      cycle(1'b0, 1'b1);
    end
    chk("latency", 512'(first), 512'(7));
    chk("valid_cycles", 512'(nv), 512'(1));
    chk("data", cap, vec_of(base, 8));

    // DIM=4, OUT_DEPTH=5: 12 pushes and 12 pops with random out_ready.
    phase = "depth5";
    sel = 1'b1;
    model_clear();
    nacc = 0; npop = 0; mx = 0;
    for (int j = 0; j < 400 && (nacc < 12 || npop < 12); j++) begin
      vv = (nacc < 12);
      rr = 1'($urandom_range(0, 1));
      if (vv && in_ready_b) nacc++;
      if (rr && out_valid_b) npop++;
      cycle(vv, rr);
      if (int'(count_b) > mx) mx = int'(count_b);
    end
    chk("accepts", 512'(nacc), 512'(12));
    chk("pops", 512'(npop), 512'(12));
    chk("count_le_5", 512'(mx <= 5), 512'(1));
    chk("count_end", 512'(count_b), 512'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/deskew_collector.md
# deskew_collector

Re-aligns the diagonally skewed result wavefront leaving the systolic array into whole row vectors, then buffers them for a valid/ready consumer. It is the output-side counterpart of the input delay fifos. Those fifos skew rows into the array so that lane i is delayed by i cycles. This block removes that skew and stores each aligned vector in an internal circular FIFO. Ingress is credit-gated, so a wavefront already in flight can never overflow storage.

## Interface
- DIM, 8, number of lanes; must be ≥2
- BITS, 64, width of one lane
- OUT_DEPTH, 16, aligned-vector FIFO entries; full throughput requires OUT_DEPTH ≥ DIM+1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  start of a wavefront; lane 0 of in_data is valid this cycle
- in_ready  out  1  credit available; a wavefront is accepted on in_valid & in_ready
- in_data  in  DIM*BITS  lane i at [i*BITS +: BITS]; lane i is valid i cycles after the accept
- out_valid  out  1  head entry present
- out_ready  in  1  consumer pops head when out_valid & out_ready
- out_data  out  DIM*BITS  head entry, lane order unchanged; 0 when empty
- count  out  $clog2(OUT_DEPTH+1)  FIFO occupancy (excludes in-flight wavefronts)

## Operation
- **Accept at edge E0.** When in_valid & in_ready is sampled at edge E0, set vld[0]. The valid pipeline is vld[0..DIM-2]. It shifts every cycle and is never stalled.
- **Lane delay.** Lane i passes through DIM-1-i registers. The first register samples in_data lane i at edge Ei, which is i edges after E0.
  - Lane DIM-1 has no register; it feeds the FIFO write port directly.
  - Lane values outside their slot are don't-care and must not corrupt any entry.
- **Push.** When vld[DIM-2]=1, the aligned vector is written at edge E_{DIM-1} into mem[wr_ptr], and wr_ptr increments.
- **Pop.** On out_valid & out_ready, rd_ptr increments.
- **Pointers.** Both pointers wrap modulo OUT_DEPTH, including non-power-of-2 depths.
- **Count update.** Push only: count+1. Pop only: count-1. Simultaneous push and pop: count unchanged, and both pointers advance.
- **Credit.** in_flight = popcount(vld). in_ready = (count + in_flight) < OUT_DEPTH.
  - in_ready is computed from registered state only and does not depend on in_valid or out_ready.
  - A same-cycle pop is not credited; this is conservative by design.
- **Overflow.** A push while count==OUT_DEPTH is impossible by construction; the bench asserts it never occurs.
- **Empty.** out_valid = (count!=0). out_data = mem[rd_ptr] when not empty, else all zeros. Both are combinational from registered state.
- **Reset (async, any time, including mid-wavefront).**
  - vld, pointers, count, all lane-delay registers and mem clear to 0.
  - In-flight wavefronts are discarded.
  - Output values during and after reset: in_ready=1, out_valid=0, out_data=0, count=0.

## Timing
- **Latency.** A wavefront accepted at E0 is written at E_{DIM-1}. out_valid rises in the cycle after E_{DIM-1}, i.e. DIM-1 cycles after the accept edge (7 for DIM=8).
- **Throughput.** One wavefront per cycle when out_ready is held high and OUT_DEPTH ≥ DIM+1. In steady state in_flight=DIM-1 and count=1.
- **Pop timing.** A pop takes effect at the edge where out_valid & out_ready are sampled. The next head entry appears in the following cycle.
- **Credit recovery.** in_ready rises in the cycle after the edge that reduces count + in_flight below OUT_DEPTH.
- **Release from reset.** The first accept can occur on the first clk edge after rst_n deasserts.

## Test plan
- **Single wavefront (DIM=8, out_ready=1).** Accept at E0, driving lane i = 64'h100+i at Ei and garbage at all other times. Required: out_valid high for exactly 1 cycle, 7 cycles after accept; out_data lanes 0..7 = 100..107; count returns to 0.
- **Streaming.** 20 back-to-back wavefronts with lane i = k*16+i for wavefront k, out_ready=1. Required: in_ready never drops, 20 consecutive out_valid cycles, in-order data; exercises wrap at 16.
- **Backpressure.** out_ready=0 with in_valid held high. Required: exactly 16 accepts in total, then in_ready=0 until a pop; count peaks at 16 with no overflow. Then set out_ready=1: 16 vectors drain in order.
- **Simultaneous push/pop.** At count=15 with a push and a pop on the same edge. Required: count stays 15, the head advances, and the data order is preserved.
- **Reset mid-flight.** Assert rst_n low 3 cycles after accepting 2 wavefronts. Required: all outputs take reset values immediately; no stale vector appears afterward; the next wavefront returns correct data at latency 7.
- **Non-power-of-2 depth (OUT_DEPTH=5, DIM=4).** Push 12 and pop 12 with random out_ready. Required: in-order data, count never exceeds 5, pointers wrap correctly.
